wb_periph_arbiter: RTL and testbench

- Two-master Wishbone arbiter in front of one peripheral slave (GPIO, timers and similar). Master 0 is the CPU data port; master 1 is the debug/DMA port.
- Grants the slave round-robin and holds the grant for a whole cyc burst.
- Muxes the slave bus to the owner and routes ack back to the owner only.
- A watchdog converts a missing ack into an err pulse.

---
 rtl/wb_periph_arbiter_pkg.sv | 19 +
 rtl/wb_arb_wdog.sv | 52 +++++
 rtl/wb_periph_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_periph_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_periph_arbiter_pkg.sv
// Shared definitions for the peripheral-bus arbiter.
//   - arb_state_e : arbiter state encoding (IDLE / OWN0 / OWN1)
//   - ADR_W, DAT_W, SEL_W : Wishbone address, data and byte-select widths
//   - TIMEOUT_DEF, CNT_W_DEF : default watchdog limit and counter width
package wb_periph_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int ADR_W       = 32;
  localparam int DAT_W       = 32;
  localparam int SEL_W       = 4;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/wb_arb_wdog.sv
// Bus watchdog for the peripheral arbiter.
// Counts consecutive strobe cycles that get no ack while a master owns the
// bus, and raises a registered one-cycle expire pulse once TIMEOUT such
// cycles have passed.
//   clk_i, rst_i : clock, synchronous active-high reset
//   active       : a master currently owns the slave
//   stb          : strobe as presented to the slave (cyc & stb)
//   ack          : slave acknowledge
//   expire       : registered timeout pulse (one cycle)
module wb_arb_wdog
  import wb_periph_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active,
  input  logic stb,
  input  logic ack,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             expire_q, expire_d;
  logic             stall;

  always_comb begin
    stall    = active & stb & ~ack;
    // An ack in the last allowed cycle clears stall, so ack beats timeout.
    expire_d = stall & (wdog_q == LIMIT);
    wdog_d   = '0;
    if (stall && !expire_d) begin
      wdog_d = wdog_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog_q   <= '0;
      expire_q <= 1'b0;
    end else begin
      wdog_q   <= wdog_d;
      expire_q <= expire_d;
    end
  end

  assign expire = expire_q;

endmodule

// File: rtl/wb_periph_arbiter.sv
// Two-master Wishbone arbiter in front of a single peripheral slave.
// Master 0 is the CPU data port, master 1 the debug/DMA port. The grant is
// registered, round-robin on ties, held for a whole cyc burst, and always
// released through IDLE. A watchdog turns a missing ack into an err pulse.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   mN_cyc/stb/adr/we/sel/dat_i : master N request
//   mN_dat_o/ack_o/err_o  : master N response (zero unless N owns the bus)
//   s_*_o                 : request forwarded to the slave (zero in IDLE)
//   s_dat_i, s_ack_i      : slave response
//   gnt_o                 : one-hot current owner
module wb_periph_arbiter
  import wb_periph_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic             m0_we_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic             m1_we_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic             s_we_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  output logic [1:0]       gnt_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       expire;
  logic       active;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next state: on a tie the master that did not own the bus last wins.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = OWN0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (expire || !m0_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      OWN1: begin
        if (expire || !m1_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: the owner is wired through; in the err cycle the slave
  // request is withdrawn and ack is masked so ack and err never coincide.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_adr_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    gnt_o    = 2'b00;
    if (state_q == OWN0) begin
      s_cyc_o  = m0_cyc_i & ~expire;
      s_stb_o  = m0_stb_i & ~expire;
      s_adr_o  = m0_adr_i;
      s_we_o   = m0_we_i;
      s_sel_o  = m0_sel_i;
      s_dat_o  = m0_dat_i;
      m0_dat_o = s_dat_i;
      m0_ack_o = s_ack_i & ~expire;
      m0_err_o = expire;
      gnt_o    = 2'b01;
    end else if (state_q == OWN1) begin
      s_cyc_o  = m1_cyc_i & ~expire;
      s_stb_o  = m1_stb_i & ~expire;
      s_adr_o  = m1_adr_i;
      s_we_o   = m1_we_i;
      s_sel_o  = m1_sel_i;
      s_dat_o  = m1_dat_i;
      m1_dat_o = s_dat_i;
      m1_ack_o = s_ack_i & ~expire;
      m1_err_o = expire;
      gnt_o    = 2'b10;
    end
  end

  assign active = (state_q != IDLE);

  wb_arb_wdog #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_wdog (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .active(active),
    .stb   (s_cyc_o & s_stb_o),
    .ack   (s_ack_i),
    .expire(expire)
  );

endmodule

// File: tb/tb_wb_periph_arbiter.sv
// Directed bench for wb_periph_arbiter with a behavioural ownership model
// checked on every falling edge, plus hand-computed literal expectations.
module tb_wb_periph_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic [1:0]  gnt_o;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  wb_periph_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_adr_i(m0_adr_i),
    .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_adr_i(m1_adr_i),
    .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o),
    .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: who owns the slave, who owned it last, how many
  // strobes in a row went unanswered, and which master is due an err.
  int own     = -1;
  int last_own = 1;
  int stall   = 0;
  int err_to  = -1;

  logic        o_cyc, o_stb, o_we, in_err;
  logic [31:0] o_adr, o_dat;
  logic [3:0]  o_sel;

  always @(negedge clk) begin
    if (chk_en) begin
      in_err = (err_to >= 0);
      if (own == 0) begin
        o_cyc = m0_cyc_i; o_stb = m0_stb_i; o_we = m0_we_i;
        o_adr = m0_adr_i; o_sel = m0_sel_i; o_dat = m0_dat_i;
      end else if (own == 1) begin
        o_cyc = m1_cyc_i; o_stb = m1_stb_i; o_we = m1_we_i;
        o_adr = m1_adr_i; o_sel = m1_sel_i; o_dat = m1_dat_i;
      end else begin
        o_cyc = 1'b0; o_stb = 1'b0; o_we = 1'b0;
        o_adr = '0; o_sel = '0; o_dat = '0;
      end
      check("m_gnt",   {30'd0, gnt_o}, (own == 0) ? 32'd1 : (own == 1) ? 32'd2 : 32'd0);
      check("m_s_cyc", {31'd0, s_cyc_o}, {31'd0, o_cyc & ~in_err});
      check("m_s_stb", {31'd0, s_stb_o}, {31'd0, o_stb & ~in_err});
      check("m_s_adr", s_adr_o, o_adr);
      check("m_s_we",  {31'd0, s_we_o}, {31'd0, o_we});
      check("m_s_sel", {28'd0, s_sel_o}, {28'd0, o_sel});
      check("m_s_dat", s_dat_o, o_dat);
      check("m_m0_ack", {31'd0, m0_ack_o}, {31'd0, (own == 0) && !in_err && s_ack_i});
      check("m_m1_ack", {31'd0, m1_ack_o}, {31'd0, (own == 1) && !in_err && s_ack_i});
      check("m_m0_err", {31'd0, m0_err_o}, {31'd0, err_to == 0});
      check("m_m1_err", {31'd0, m1_err_o}, {31'd0, err_to == 1});
      check("m_m0_dat", m0_dat_o, (own == 0) ? s_dat_i : 32'd0);
      check("m_m1_dat", m1_dat_o, (own == 1) ? s_dat_i : 32'd0);

      if (rst_i) begin
        own = -1; last_own = 1; stall = 0; err_to = -1;
      end else if (own < 0) begin
        stall = 0; err_to = -1;
        if (m0_cyc_i && m1_cyc_i) own = (last_own == 0) ? 1 : 0;
        else if (m0_cyc_i) own = 0;
        else if (m1_cyc_i) own = 1;
      end else if (err_to >= 0) begin
        last_own = own; own = -1; err_to = -1; stall = 0;
      end else begin
        if (o_cyc && o_stb && !s_ack_i) begin
          stall++;
          if (stall == TO) begin
            err_to = own;
            stall  = 0;
          end
        end else begin
          stall = 0;
        end
        if (err_to < 0 && !o_cyc) begin
          last_own = own; own = -1;
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = 0; m0_sel_i = 0; m0_dat_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = 0; m1_sel_i = 0; m1_dat_i = 0;
    s_dat_i = 0; s_ack_i = 0;
    step();
    chk_en = 1'b1;
    check("rst_gnt", {30'd0, gnt_o}, 32'd0);
    check("rst_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    check("rst_m0_err", {31'd0, m0_err_o}, 32'd0);

    // Single master write
    rst_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 32'h0; m0_sel_i = 4'b0001; m0_dat_i = 32'hA5;
    #1 check("req_cycle_gnt", {30'd0, gnt_o}, 32'd0);
    check("req_cycle_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    step();
    check("wr_gnt", {30'd0, gnt_o}, 32'd1);
    check("wr_s_dat", s_dat_o, 32'h0000_00A5);
    check("wr_s_sel", {28'd0, s_sel_o}, 32'd1);
    s_ack_i = 1;
    #1 check("wr_m0_ack", {31'd0, m0_ack_o}, 32'd1);
    check("wr_m1_ack", {31'd0, m1_ack_o}, 32'd0);
    step();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_dat_i = 0; s_ack_i = 0;
    step();
    check("wr_done_gnt", {30'd0, gnt_o}, 32'd0);

    // Tie after reset
    rst_i = 1; step(); rst_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h10;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h20;
    step();
    check("tie1_gnt", {30'd0, gnt_o}, 32'd1);
    check("tie1_adr", s_adr_o, 32'h10);
    s_ack_i = 1;
    #1 check("tie1_m1_ack", {31'd0, m1_ack_o}, 32'd0);
    step();
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
    step();
    check("tie1_idle_gnt", {30'd0, gnt_o}, 32'd0);
    step();
    check("tie1_m1_gnt", {30'd0, gnt_o}, 32'd2);
    check("tie1_m1_adr", s_adr_o, 32'h20);
    s_ack_i = 1;
    step();
    m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
    step();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    step();
    check("tie2_gnt", {30'd0, gnt_o}, 32'd1);
    s_ack_i = 1;
    step();
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
    step();
    step();
    check("tie2_m1_gnt", {30'd0, gnt_o}, 32'd2);
    s_ack_i = 1;
    step();
    m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
    step();

    // Burst hold: m0 three reads while m1 waits
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h0; m0_sel_i = 4'hF;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h100;
    step();
    check("burst_gnt", {30'd0, gnt_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      m0_adr_i = 32'(4 * i); s_ack_i = 1; s_dat_i = 32'h50 + 32'(i);
      #1 check("burst_adr", s_adr_o, 32'(4 * i));
      check("burst_m0_dat", m0_dat_o, 32'h50 + 32'(i));
      check("burst_m1_ack", {31'd0, m1_ack_o}, 32'd0);
      check("burst_m1_dat", m1_dat_o, 32'd0);
      step();
    end
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0; s_dat_i = 0;
    #1 check("burst_hold_gnt", {30'd0, gnt_o}, 32'd1);
    step();
    check("burst_idle_gnt", {30'd0, gnt_o}, 32'd0);
    check("burst_idle_cyc", {31'd0, s_cyc_o}, 32'd0);
    step();
    check("burst_m1_gnt", {30'd0, gnt_o}, 32'd2);
    check("burst_m1_adr", s_adr_o, 32'h100);

    // Read return to m1
    s_dat_i = 32'h1234_5678; s_ack_i = 1;
    #1 check("rd_m1_dat", m1_dat_o, 32'h1234_5678);
    check("rd_m0_dat", m0_dat_o, 32'd0);
    check("rd_m1_ack", {31'd0, m1_ack_o}, 32'd1);
    step();
    m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0; s_dat_i = 0;
    step();

    // Timeout: no ack ever
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h40;
    step();
    check("to_stb_first", {31'd0, s_stb_o}, 32'd1);
    step(); step(); step();
    check("to_no_err_early", {31'd0, m0_err_o}, 32'd0);
    step();
    check("to_err", {31'd0, m0_err_o}, 32'd1);
    check("to_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    check("to_m0_ack", {31'd0, m0_ack_o}, 32'd0);
    m0_cyc_i = 0; m0_stb_i = 0;
    step();
    check("to_err_once", {31'd0, m0_err_o}, 32'd0);
    check("to_idle_gnt", {30'd0, gnt_o}, 32'd0);

    // Timeout variant: ack in the 4th strobe cycle
    m0_cyc_i = 1; m0_stb_i = 1;
    step(); step(); step(); step();
    s_ack_i = 1;
    #1 check("tov_ack", {31'd0, m0_ack_o}, 32'd1);
    step();
    s_ack_i = 0;
    #1 check("tov_no_err", {31'd0, m0_err_o}, 32'd0);
    m0_cyc_i = 0; m0_stb_i = 0;
    step();
    check("tov_no_err2", {31'd0, m0_err_o}, 32'd0);

    // Reset while m1 owns
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h80;
    step();
    check("rm_gnt", {30'd0, gnt_o}, 32'd2);
    step();
    rst_i = 1;
    step();
    check("rm_rst_gnt", {30'd0, gnt_o}, 32'd0);
    check("rm_rst_cyc", {31'd0, s_cyc_o}, 32'd0);
    check("rm_rst_err", {31'd0, m1_err_o}, 32'd0);
    rst_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'hC0;
    step();
    check("rm_tie_gnt", {30'd0, gnt_o}, 32'd1);
    m0_cyc_i = 0; m0_stb_i = 0;
    step();
    step();
    check("rm_m1_gnt", {30'd0, gnt_o}, 32'd2);
    m1_cyc_i = 0; m1_stb_i = 0;
    step();
    step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
